// File: rtl/bp_nbf_axil_host_bridge.sv
// AXI4-Lite slave bridging the NBF loader's write stream into 136-bit commands and buffering
// 64-bit host responses for polled reads. Optional macro: BP_NBF_HOST_BRIDGE_PAD_CHECK_EN.
module bp_nbf_axil_host_bridge #(
    parameter int unsigned S_AXIL_ADDR_WIDTH = 64,
    parameter int unsigned S_AXIL_DATA_WIDTH = 32,
    parameter logic [63:0] nbf_host_addr_p   = 64'h0,
    parameter int unsigned resp_fifo_els_p   = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [2:0]                     s_axil_awprot,

    input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,

    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,

    input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    input  logic [2:0]                     s_axil_arprot,

    output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,

    output logic [135:0]                   nbf_o,
    output logic                           nbf_v_o,
    input  logic                           nbf_ready_and_i,

    input  logic [63:0]                    resp_i,
    input  logic                           resp_v_i,
    output logic                           resp_ready_and_o
);

    localparam int unsigned ptr_w = $clog2(resp_fifo_els_p);
    localparam int unsigned cnt_w = $clog2(resp_fifo_els_p + 1);
    localparam logic [S_AXIL_ADDR_WIDTH-1:0] host_addr = S_AXIL_ADDR_WIDTH'(nbf_host_addr_p);
    localparam logic [S_AXIL_ADDR_WIDTH-1:0] cnt_addr  = S_AXIL_ADDR_WIDTH'('h10);
    localparam logic [S_AXIL_ADDR_WIDTH-1:0] lo_addr   = S_AXIL_ADDR_WIDTH'('h14);
    localparam logic [S_AXIL_ADDR_WIDTH-1:0] hi_addr   = S_AXIL_ADDR_WIDTH'('h18);

    typedef enum logic {e_collect, e_resp} wr_state_e;
    typedef enum logic {e_ridle, e_rvalid} rd_state_e;

    wr_state_e wr_state_r, wr_state_n;
    rd_state_e rd_state_r, rd_state_n;

    logic                         aw_full_r, w_full_r;
    logic [S_AXIL_ADDR_WIDTH-1:0] aw_addr_r;
    logic [S_AXIL_DATA_WIDTH-1:0] w_data_r;
    logic [2:0]                   flit_r;
    logic [135:0]                 nbf_r;
    logic                         nbf_v_r;
    logic [1:0]                   bresp_r, rresp_r, rresp_n;
    logic [S_AXIL_DATA_WIDTH-1:0] rdata_r, rdata_n;

    logic [63:0]      mem_r [resp_fifo_els_p];
    logic [ptr_w-1:0] wptr_r, rptr_r;
    logic [cnt_w-1:0] cnt_r;

    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb};

    // Write side: a beat may complete in the same cycle as its later channel handshake.
    logic accept_en, aw_fire, w_fire, beat, hit, pad_bad;
    logic [S_AXIL_ADDR_WIDTH-1:0] cur_addr;
    logic [S_AXIL_DATA_WIDTH-1:0] cur_data;

    assign accept_en      = (wr_state_r == e_collect) & ~nbf_v_r;
    assign s_axil_awready = accept_en & ~aw_full_r;
    assign s_axil_wready  = accept_en & ~w_full_r;
    assign aw_fire        = s_axil_awvalid & s_axil_awready;
    assign w_fire         = s_axil_wvalid & s_axil_wready;
    assign cur_addr       = aw_full_r ? aw_addr_r : s_axil_awaddr;
    assign cur_data       = w_full_r ? w_data_r : s_axil_wdata;
    assign beat           = accept_en & (aw_full_r | aw_fire) & (w_full_r | w_fire);
    assign hit            = (cur_addr == host_addr);
`ifdef BP_NBF_HOST_BRIDGE_PAD_CHECK_EN
    assign pad_bad        = (flit_r == 3'd4) & (|cur_data[31:8]);
`else
    assign pad_bad        = 1'b0;
`endif

    always_comb begin
        wr_state_n = wr_state_r;
        unique case (wr_state_r)
            e_collect: if (beat) wr_state_n = e_resp;
            e_resp:    if (s_axil_bready) wr_state_n = e_collect;
            default:   wr_state_n = e_collect;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_state_r <= e_collect;
            aw_full_r  <= 1'b0;
            w_full_r   <= 1'b0;
            aw_addr_r  <= '0;
            w_data_r   <= '0;
            flit_r     <= 3'd0;
            nbf_r      <= '0;
            nbf_v_r    <= 1'b0;
            bresp_r    <= 2'b00;
        end else begin
            wr_state_r <= wr_state_n;
            if (beat) begin
                aw_full_r <= 1'b0;
                w_full_r  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_full_r <= 1'b1;
                    aw_addr_r <= s_axil_awaddr;
                end
                if (w_fire) begin
                    w_full_r <= 1'b1;
                    w_data_r <= s_axil_wdata;
                end
            end
            if (nbf_v_r & nbf_ready_and_i) nbf_v_r <= 1'b0;
            if (beat) begin
                bresp_r <= (hit & ~pad_bad) ? 2'b00 : 2'b10;
                if (hit) begin
                    flit_r <= (flit_r == 3'd4) ? 3'd0 : flit_r + 3'd1;
                    case (flit_r)
                        3'd0:    nbf_r[31:0]    <= cur_data[31:0];
                        3'd1:    nbf_r[63:32]   <= cur_data[31:0];
                        3'd2:    nbf_r[95:64]   <= cur_data[31:0];
                        3'd3:    nbf_r[127:96]  <= cur_data[31:0];
                        default: nbf_r[135:128] <= cur_data[7:0];
                    endcase
                    if ((flit_r == 3'd4) & ~pad_bad) nbf_v_r <= 1'b1;
                end
            end
        end
    end

    assign s_axil_bvalid = (wr_state_r == e_resp);
    assign s_axil_bresp  = bresp_r;
    assign nbf_o         = nbf_r;
    assign nbf_v_o       = nbf_v_r;

    // Read side and response FIFO; occupancy reads see the count before this cycle's enqueue.
    logic ar_fire, fifo_empty, fifo_full, pop, enq;
    logic [63:0] head;

    assign fifo_empty       = (cnt_r == '0);
    assign fifo_full        = (cnt_r == cnt_w'(resp_fifo_els_p));
    assign head             = mem_r[rptr_r];
    assign resp_ready_and_o = ~fifo_full;
    assign enq              = resp_v_i & ~fifo_full;
    assign s_axil_arready   = (rd_state_r == e_ridle);
    assign ar_fire          = s_axil_arvalid & s_axil_arready;
    assign pop              = ar_fire & (s_axil_araddr == lo_addr) & ~fifo_empty;

    always_comb begin
        rd_state_n = rd_state_r;
        rdata_n    = '0;
        rresp_n    = 2'b00;
        unique case (rd_state_r)
            e_ridle:  if (ar_fire) rd_state_n = e_rvalid;
            e_rvalid: if (s_axil_rready) rd_state_n = e_ridle;
            default:  rd_state_n = e_ridle;
        endcase
        if (s_axil_araddr == cnt_addr)     rdata_n = S_AXIL_DATA_WIDTH'(cnt_r);
        else if (s_axil_araddr == lo_addr) rdata_n = fifo_empty ? '0 : head[31:0];
        else if (s_axil_araddr == hi_addr) rdata_n = fifo_empty ? '0 : head[63:32];
        else                               rresp_n = 2'b10;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_state_r <= e_ridle;
            rdata_r    <= '0;
            rresp_r    <= 2'b00;
            wptr_r     <= '0;
            rptr_r     <= '0;
            cnt_r      <= '0;
        end else begin
            rd_state_r <= rd_state_n;
            if (ar_fire) begin
                rdata_r <= rdata_n;
                rresp_r <= rresp_n;
            end
            if (enq) wptr_r <= (wptr_r == ptr_w'(resp_fifo_els_p - 1)) ? '0 : wptr_r + 1'b1;
            if (pop) rptr_r <= (rptr_r == ptr_w'(resp_fifo_els_p - 1)) ? '0 : rptr_r + 1'b1;
            cnt_r <= cnt_r + cnt_w'(enq) - cnt_w'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= resp_i;
    end

    assign s_axil_rvalid = (rd_state_r == e_rvalid);
    assign s_axil_rdata  = rdata_r;
    assign s_axil_rresp  = rresp_r;

endmodule
